// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipelined processor.
// Holds DEPTH words of N bits, services synchronous writes and registered
// reads (latency 1), and contains a dump sequencer that streams every word
// out over a valid/ready port. The responder asserts busy while dumping, and
// processor requests are ignored during that time.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   memRead, memWrite          processor read / write requests
//   address, writeData         word address and write data
//   readData, readValid        registered read response
//   busy                       dump in progress (processor stalls)
//   dump                       level request to dump the whole memory
//   dump_valid, dump_ready     dump stream handshake
//   dump_addr, dump_data       presented dump word and its index
//   dump_done                  one-cycle pulse after the last word is accepted
//
// Optional build macro:
//   DMEM_SKIP_ZERO_EN          zero-valued words are skipped during a dump
module dmem_responder #(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memRead,
  input  logic          memWrite,
  input  logic [AW-1:0] address,
  input  logic [N-1:0]  writeData,
  output logic [N-1:0]  readData,
  output logic          readValid,
  output logic          busy,
  input  logic          dump,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [N-1:0]  dump_data,
  output logic          dump_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_index;
  logic [AW-1:0] w_index_nxt;

  logic [N-1:0]  r_mem [DEPTH];

  logic          w_addr_ok;
  logic          w_wr_en;
  logic          w_last;
  logic          w_advance;
  logic [N-1:0]  w_next_word;
  logic [N-1:0]  w_read_data_nxt;
  logic          w_read_valid_nxt;
  logic          w_busy_nxt;
  logic          w_dump_valid_nxt;
  logic          w_dump_done_nxt;

  assign w_addr_ok = (32'(address) < DEPTH);
  assign w_wr_en   = (r_state == S_IDLE) && memWrite && w_addr_ok;
  assign w_last    = (r_index == AW'(DEPTH - 1));

  // A presented word moves on when accepted; in skip mode an unpresented
  // (zero) word moves on by itself.
`ifdef DMEM_SKIP_ZERO_EN
  assign w_advance = (r_state == S_DUMP) && (!dump_valid || dump_ready);
`else
  assign w_advance = (r_state == S_DUMP) && dump_ready;
`endif

  // Memory array: not touched by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[address] <= writeData;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    case (r_state)
      S_IDLE: begin
        if (dump) begin
          w_state_nxt = S_DUMP;
          w_index_nxt = '0;
        end
      end
      S_DUMP: begin
        if (w_advance) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_index_nxt = '0;
          end else begin
            w_index_nxt = r_index + AW'(1);
          end
        end
      end
      S_DONE: begin
        if (!dump) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_index_nxt = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_read_data_nxt  = readData;
    w_read_valid_nxt = 1'b0;
    if ((r_state == S_IDLE) && memRead) begin
      w_read_data_nxt  = w_addr_ok ? r_mem[address] : '0;
      w_read_valid_nxt = 1'b1;
    end

    // Forward a write landing in the dump-entry cycle so word 0 is current.
    w_next_word = r_mem[w_index_nxt];
    if (w_wr_en && (address == w_index_nxt)) begin
      w_next_word = writeData;
    end

`ifdef DMEM_SKIP_ZERO_EN
    w_dump_valid_nxt = (w_state_nxt == S_DUMP) && (w_next_word != '0);
`else
    w_dump_valid_nxt = (w_state_nxt == S_DUMP);
`endif
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_dump_done_nxt = (r_state == S_DUMP) && (w_state_nxt == S_DONE);
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readData   <= '0;
      readValid  <= 1'b0;
      busy       <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      readData   <= w_read_data_nxt;
      readValid  <= w_read_valid_nxt;
      busy       <= w_busy_nxt;
      dump_valid <= w_dump_valid_nxt;
      dump_data  <= w_next_word;
      dump_done  <= w_dump_done_nxt;
    end
  end

  assign dump_addr = r_index;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected read and dump
// responses into queues, and a negedge monitor pops and compares them.
module tb_dmem_responder;
  localparam int unsigned N     = 64;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
`ifdef DMEM_SKIP_ZERO_EN
  localparam int EXP_BEATS = 63;
`else
  localparam int EXP_BEATS = 64;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          memRead = 1'b0;
  logic          memWrite = 1'b0;
  logic [AW-1:0] address = '0;
  logic [N-1:0]  writeData = '0;
  logic [N-1:0]  readData;
  logic          readValid;
  logic          busy;
  logic          dump = 1'b0;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  dump_data;
  logic          dump_done;

  always #5 clk = ~clk;

  dmem_responder #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .readData(readData),
    .readValid(readValid), .busy(busy), .dump(dump), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_beats = 0;
  int n_done = 0;

  logic [N-1:0]  q_rd[$];
  logic [AW-1:0] q_da[$];
  logic [N-1:0]  q_dd[$];

  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [N-1:0]  p_data = '0;

  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (reset) begin
      if (readValid) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 64'(readValid), 64'd0);
        else chk("rd_data", readData, q_rd.pop_front());
      end
      if (dump_valid && dump_ready) begin
        n_beats++;
        if (q_da.size() == 0) chk("dump_unexpected", 64'(dump_valid), 64'd0);
        else begin
          chk("dump_addr", 64'(dump_addr), 64'(q_da.pop_front()));
          chk("dump_data", dump_data, q_dd.pop_front());
        end
      end
      if (p_valid && !p_ready && dump_valid) begin
        chk("stall_addr_stable", 64'(dump_addr), 64'(p_addr));
        chk("stall_data_stable", dump_data, p_data);
      end
      if (dump_done) n_done++;
      p_valid = dump_valid;
      p_ready = dump_ready;
      p_addr  = dump_addr;
      p_data  = dump_data;
    end else begin
      p_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [N-1:0] d);
    address = AW'(a); writeData = d; memWrite = 1'b1;
    tick();
    memWrite = 1'b0;
  endtask

  task automatic do_read(input int a, input logic [N-1:0] e);
    address = AW'(a); memRead = 1'b1;
    q_rd.push_back(e);
    tick();
    memRead = 1'b0;
  endtask

  task automatic do_rmw(input int a, input logic [N-1:0] d, input logic [N-1:0] e);
    address = AW'(a); writeData = d; memWrite = 1'b1; memRead = 1'b1;
    q_rd.push_back(e);
    tick();
    memWrite = 1'b0; memRead = 1'b0;
  endtask

  task automatic push_dump_all();
    for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef DMEM_SKIP_ZERO_EN
      if (i == 0) continue;
`endif
      q_da.push_back(AW'(i));
      q_dd.push_back(N'(i));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_readData"}, readData, 64'd0);
    chk({tag, "_readValid"}, 64'(readValid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_dump_addr"}, 64'(dump_addr), 64'd0);
    chk({tag, "_dump_done"}, 64'(dump_done), 64'd0);
    chk({tag, "_dump_data"}, dump_data, 64'd0);
  endtask

  int cyc, bl, nb0, nd0;

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Basic write/read and read-before-write
    do_write(5, 64'h0000_0000_DEAD_BEEF);
    do_read(5, 64'h0000_0000_DEAD_BEEF);
    do_write(3, 64'h11);
    do_rmw(3, 64'h22, 64'h11);
    do_read(3, 64'h22);

    // Fill mem[i] = i
    for (int i = 0; i < int'(DEPTH); i++) do_write(i, N'(i));
    do_read(10, 64'd10);
    do_read(63, 64'd63);
    tick(); tick();

    // Full dump with dump_ready held high; dump released after one cycle
    nb0 = n_beats; nd0 = n_done;
    push_dump_all();
    dump = 1'b1; dump_ready = 1'b1;
    tick();
    dump = 1'b0;
    cyc = 1; bl = 0;
    while (!dump_done && cyc < 300) begin
      if (!busy) bl++;
      tick();
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'd65);
    chk("busy_during_dump", 64'(bl), 64'd0);
    chk("busy_in_done", 64'(busy), 64'd1);
    tick();
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_pulse_width", 64'(dump_done), 64'd0);
    chk("dump_beats", 64'(n_beats - nb0), 64'(EXP_BEATS));
    chk("done_count", 64'(n_done - nd0), 64'd1);

    // Dump with dump_ready pattern 1,0,0,1 and an ignored write/read to addr 0
    nb0 = n_beats; nd0 = n_done;
    push_dump_all();
    dump = 1'b1;
    cyc = 0;
    while (!dump_done && cyc < 400) begin
      dump_ready = pat[cyc % 4];
      if (cyc == 3) begin
        address = '0; writeData = 64'hBAD; memWrite = 1'b1; memRead = 1'b1;
      end
      tick();
      memWrite = 1'b0; memRead = 1'b0;
      cyc++;
    end
    chk("toggle_dump_done", 64'(dump_done), 64'd1);
    chk("toggle_beats", 64'(n_beats - nb0), 64'(EXP_BEATS));
    // dump held high in DONE: no restart
    dump_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_no_valid", 64'(dump_valid), 64'd0);
    end
    chk("hold_done_count", 64'(n_done - nd0), 64'd1);
    dump = 1'b0;
    tick();
    chk("release_busy", 64'(busy), 64'd0);
    do_read(0, 64'd0);
    do_read(63, 64'd63);
    tick(); tick();

    // Reset in the middle of a dump
    nd0 = n_done;
    push_dump_all();
    dump = 1'b1; dump_ready = 1'b1;
    repeat (11) tick();
    reset = 1'b0;
    #1 chk_all_zero("abort");
    q_da.delete(); q_dd.delete();
    dump = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (70) tick();
    chk("abort_no_done", 64'(n_done - nd0), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    do_read(10, 64'd10);
    tick(); tick();

`ifdef DMEM_SKIP_ZERO_EN
    // Only mem[7] nonzero: a single presented beat
    for (int i = 0; i < int'(DEPTH); i++) do_write(i, (i == 7) ? 64'd7 : 64'd0);
    nb0 = n_beats;
    q_da.push_back(AW'(7)); q_dd.push_back(N'(7));
    dump = 1'b1; dump_ready = 1'b1;
    tick();
    dump = 1'b0;
    cyc = 1;
    while (!dump_done && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("skip_latency", 64'(cyc), 64'd65);
    chk("skip_beats", 64'(n_beats - nb0), 64'd1);
    tick(); tick();
`endif

    chk("rd_queue_empty", 64'(q_rd.size()), 64'd0);
    chk("dump_queue_empty", 64'(q_da.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined processor: the memory side of the DM interface (address, write data, write enable, read enable).
- Holds DEPTH words of N bits. Performs synchronous writes and registered reads.
- Contains a dump sequencer that streams every word out over a valid/ready port for the testbench or host.
- While a dump is in progress it asserts busy, and the processor stalls on busy.

Parameters:
- N, 64, data word width in bits
- DEPTH, 64, number of words
- AW, 6, word-address width; DEPTH <= 2**AW

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset
- memRead  in  1  read request from processor
- memWrite  in  1  write request from processor
- address  in  AW  word address (processor supplies byte address bits [AW+2:3])
- writeData  in  N  write data
- readData  out  N  registered read data
- readValid  out  1  readData valid this cycle
- busy  out  1  responder is dumping; requests are ignored
- dump  in  1  level request to dump the whole memory
- dump_valid  out  1  dump word presented
- dump_ready  in  1  consumer accepts dump word
- dump_addr  out  AW  index of the presented word
- dump_data  out  N  contents of the presented word
- dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - readData=0, readValid=0, busy=0, dump_valid=0, dump_addr=0, dump_done=0; FSM goes to IDLE.
  - Memory contents are not modified by reset. Simulation initialises them to 0 at time 0.
- FSM states: IDLE, DUMP, DONE.
- IDLE:
  - Write: if memWrite=1, mem[address] <= writeData at the edge.
  - Read: if memRead=1, readData <= mem[address] and readValid <= 1 at the edge (latency 1). Otherwise readValid <= 0 and readData holds its value.
  - memRead and memWrite both 1: write is performed; readData returns the old contents (read-before-write).
  - address >= DEPTH: write is dropped; read returns 0 with readValid=1.
  - dump=1 → DUMP with index=0. Any request in that same cycle is still serviced.
- DUMP:
  - busy=1, dump_valid=1, dump_addr=index, dump_data=mem[index].
  - memRead/memWrite are ignored; readValid=0.
  - dump_ready=1 → index+1. dump_ready=0 → all dump outputs held stable.
  - Word at index DEPTH-1 accepted → DONE; dump_done=1 for exactly that next cycle; dump_valid=0.
  - dump deasserted mid-dump: no effect; the dump always completes.
- DONE:
  - busy=1, dump_done pulses only on the entry cycle.
  - Stays in DONE while dump=1, so no automatic restart. dump=0 → IDLE with busy=0 on the next cycle.
- Reset mid-dump aborts immediately: IDLE, index=0, no dump_done.
- Width rule: index is AW bits and never wraps past DEPTH-1.

Optional Feature:
- DMEM_SKIP_ZERO_EN defined:
  - In DUMP, a word equal to 0 is not presented: dump_valid=0 and index advances by 1 per cycle without waiting for dump_ready.
  - If index DEPTH-1 is zero, the FSM goes straight to DONE with the dump_done pulse.
  - A memory of all zeros produces no valid beats, and dump_done arrives DEPTH+1 cycles after entry to DUMP.
- Not defined: every index 0..DEPTH-1 is presented regardless of value.

Test Plan:
- Write 0x0000_0000_DEAD_BEEF to address 5, then read address 5 → next cycle readValid=1, readData=0xDEADBEEF.
- Memory pre-written with 0x11 at address 3; memRead=memWrite=1, address 3, writeData 0x22 → readData=0x11; a following read returns 0x22.
- Write mem[i]=i for all i, dump=1, dump_ready=1 → 64 beats with dump_addr=dump_data=0..63, one per cycle; dump_done pulses once; busy=1 throughout.
- Dump with dump_ready toggled 1,0,0,1 → dump_addr/dump_data stable while dump_ready=0; no index skipped; memWrite to address 0 during the dump leaves mem[0] unchanged.
- dump held high after DONE → no second dump; deassert dump → busy=0 on the next cycle; a read then works.
- reset=0 at beat 10 of a dump → all outputs 0 immediately, no dump_done. With DMEM_SKIP_ZERO_EN and only mem[7]=0x7 nonzero → exactly one valid beat (addr 7).
